// File: rtl/tt_mux_pkg.sv
// Shared types and iw/ow field layout for the Tiny Tapeout project mux scheduler.
// Optional build macro used by this slice: MUX_SCHED_OE_MASK_EN (see tt_mux_ow_sel).
package tt_mux_pkg;

  localparam int IW_W = 18;
  localparam int OW_W = 24;

  // iw bus layout {uio_in, ui_in, rst_n, clk}
  localparam int IW_CLK    = 0;
  localparam int IW_RSTN   = 1;
  localparam int IW_UI_LO  = 2;
  localparam int IW_UI_HI  = 9;
  localparam int IW_UIO_LO = 10;
  localparam int IW_UIO_HI = 17;

  // ow bus layout {uio_oe, uio_out, uo_out}
  localparam int OW_UO_LO  = 0;
  localparam int OW_UO_HI  = 7;
  localparam int OW_UIO_LO = 8;
  localparam int OW_UIO_HI = 15;
  localparam int OW_OE_LO  = 16;
  localparam int OW_OE_HI  = 23;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RESET  = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tt_mux_ow_sel.sv
// N_PROJ:1 ow return mux with a registered, clearable output.
// With MUX_SCHED_OE_MASK_EN defined, uio_out bits are gated by the project's uio_oe.
module tt_mux_ow_sel
  import tt_mux_pkg::*;
#(
  parameter int N_PROJ = 16,
  parameter int SEL_W  = $clog2(N_PROJ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_PROJ*OW_W-1:0] proj_ow,
  output logic [OW_W-1:0]        ext_ow
);

  logic [OW_W-1:0] mux_ow;
  logic [OW_W-1:0] masked_ow;
  logic [OW_W-1:0] ext_ow_d;
  logic [OW_W-1:0] ext_ow_q;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    mux_ow = '0;
    for (int k = 0; k < N_PROJ; k++) begin
      if (sel == SEL_W'(k)) mux_ow = proj_ow[k*OW_W +: OW_W];
    end
  end

  always_comb begin
    masked_ow = mux_ow;
`ifdef MUX_SCHED_OE_MASK_EN
    masked_ow[OW_UIO_HI:OW_UIO_LO] = mux_ow[OW_UIO_HI:OW_UIO_LO] & mux_ow[OW_OE_HI:OW_OE_LO];
`else
    masked_ow = mux_ow;
`endif
    ext_ow_d = clear ? '0 : masked_ow;
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) ext_ow_q <= '0;
    else     ext_ow_q <= ext_ow_d;
  end

  assign ext_ow = ext_ow_q;

endmodule

// File: rtl/tt_mux_sched.sv
// Break-before-make project select sequencer: DRAIN guard, RESET hold, then ACTIVE.
// Build option MUX_SCHED_OE_MASK_EN is consumed by tt_mux_ow_sel.
module tt_mux_sched
  import tt_mux_pkg::*;
#(
  parameter int N_PROJ    = 16,
  parameter int SEL_W     = $clog2(N_PROJ),
  parameter int GUARD_CYC = 4,
  parameter int RST_HOLD  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sel_req,
  input  logic [SEL_W-1:0]       sel_addr,
  input  logic                   sel_off,
  output logic                   sel_ack,
  output logic                   sel_err,
  output logic                   sel_done,
  output logic                   busy,
  output logic [SEL_W-1:0]       cur_sel,
  output logic [N_PROJ-1:0]      proj_ena,
  input  logic [IW_W-1:0]        ext_iw,
  output logic [IW_W-1:0]        proj_iw,
  input  logic [N_PROJ*OW_W-1:0] proj_ow,
  output logic [OW_W-1:0]        ext_ow
);

  localparam int CNT_W = $clog2(max_int(GUARD_CYC, RST_HOLD) + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    tgt_q, tgt_d;
  logic                off_q, off_d;
  logic [SEL_W-1:0]    cur_sel_q, cur_sel_d;
  logic [N_PROJ-1:0]   proj_ena_q, proj_ena_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sel_rdy;
  logic                addr_ok;
  logic                live_d;

  // With a power-of-two project count every encodable address is valid.
  generate
    if (N_PROJ == (1 << SEL_W)) begin : g_full
      assign addr_ok = 1'b1;
    end else begin : g_part
      assign addr_ok = (sel_addr < SEL_W'(N_PROJ));
    end
  endgenerate

  assign sel_rdy = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  assign sel_ack = sel_req & sel_rdy & ~sel_off & addr_ok;
  assign sel_err = sel_req & sel_rdy & ~sel_off & ~addr_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    off_d   = off_q;
    case (state_q)
      ST_IDLE, ST_ACTIVE: begin
        if (sel_off) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(GUARD_CYC - 1);
          off_d   = 1'b1;
        end else if (sel_ack) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(GUARD_CYC - 1);
          tgt_d   = sel_addr;
          off_d   = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = off_q ? ST_IDLE : ST_RESET;
          cnt_d   = CNT_W'(RST_HOLD - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESET: begin
        if (cnt_q == '0) state_d = ST_ACTIVE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs follow the next state so they line up with the state they describe.
  always_comb begin
    live_d     = (state_d == ST_RESET) || (state_d == ST_ACTIVE);
    cur_sel_d  = live_d ? tgt_d : '0;
    proj_ena_d = '0;
    for (int k = 0; k < N_PROJ; k++) begin
      if (live_d && (tgt_d == SEL_W'(k))) proj_ena_d[k] = 1'b1;
    end
    busy_d = (state_d == ST_DRAIN) || (state_d == ST_RESET);
    done_d = (state_q == ST_RESET) && (state_d == ST_ACTIVE);
  end

  always_comb begin
    proj_iw = '0;
    case (state_q)
      ST_ACTIVE: proj_iw = ext_iw;
      ST_RESET: begin
        proj_iw          = ext_iw;
        proj_iw[IW_RSTN] = 1'b0;
      end
      default: proj_iw = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tgt_q      <= '0;
      off_q      <= 1'b0;
      cur_sel_q  <= '0;
      proj_ena_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      off_q      <= off_d;
      cur_sel_q  <= cur_sel_d;
      proj_ena_q <= proj_ena_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  tt_mux_ow_sel #(
    .N_PROJ (N_PROJ),
    .SEL_W  (SEL_W)
  ) u_ow_sel (
    .clk     (clk),
    .rst     (rst),
    .clear   (~live_d),
    .sel     (cur_sel_d),
    .proj_ow (proj_ow),
    .ext_ow  (ext_ow)
  );

  assign sel_done = done_q;
  assign busy     = busy_q;
  assign cur_sel  = cur_sel_q;
  assign proj_ena = proj_ena_q;

endmodule

// File: tb/tb_tt_mux_sched.sv
// Self-checking bench for tt_mux_sched: directed sequencing checks plus an ext_ow scoreboard.
// Honours MUX_SCHED_OE_MASK_EN when computing expected uio_out.
module tb_tt_mux_sched;
  import tt_mux_pkg::*;

  localparam int N_PROJ = 16;
  localparam int SEL_W  = 5;
  localparam int G      = 4;
  localparam int H      = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   sel_req;
  logic [SEL_W-1:0]       sel_addr;
  logic                   sel_off;
  logic                   sel_ack;
  logic                   sel_err;
  logic                   sel_done;
  logic                   busy;
  logic [SEL_W-1:0]       cur_sel;
  logic [N_PROJ-1:0]      proj_ena;
  logic [IW_W-1:0]        ext_iw;
  logic [IW_W-1:0]        proj_iw;
  logic [N_PROJ*OW_W-1:0] proj_ow;
  logic [OW_W-1:0]        ext_ow;

  int n_vec = 0;
  int n_err = 0;
  logic [OW_W-1:0] sb_q[$];

  tt_mux_sched #(
    .N_PROJ    (N_PROJ),
    .SEL_W     (SEL_W),
    .GUARD_CYC (G),
    .RST_HOLD  (H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel_req  (sel_req),
    .sel_addr (sel_addr),
    .sel_off  (sel_off),
    .sel_ack  (sel_ack),
    .sel_err  (sel_err),
    .sel_done (sel_done),
    .busy     (busy),
    .cur_sel  (cur_sel),
    .proj_ena (proj_ena),
    .ext_iw   (ext_iw),
    .proj_iw  (proj_iw),
    .proj_ow  (proj_ow),
    .ext_ow   (ext_ow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; stimulus is driven there.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW_W-1:0] exp_ow(input logic [OW_W-1:0] s);
    logic [OW_W-1:0] r;
    r = s;
`ifdef MUX_SCHED_OE_MASK_EN
    r[15:8] = s[15:8] & s[23:16];
`endif
    return r;
  endfunction

  task automatic rand_ow();
    for (int k = 0; k < N_PROJ; k++) proj_ow[k*OW_W +: OW_W] = 24'($urandom);
  endtask

  initial begin
    rst      = 1'b1;
    sel_req  = 1'b0;
    sel_addr = '0;
    sel_off  = 1'b0;
    ext_iw   = '1;
    rand_ow();

    // Reset state
    repeat (3) cyc();
    #1;
    check("rst_ena",  64'(proj_ena), 64'(0));
    check("rst_cur",  64'(cur_sel),  64'(0));
    check("rst_ow",   64'(ext_ow),   64'(0));
    check("rst_busy", 64'(busy),     64'(0));
    check("rst_done", 64'(sel_done), 64'(0));
    check("rst_iw",   64'(proj_iw),  64'(0));
    cyc();
    rst = 1'b0;

    // Select project 3 from IDLE, with a busy-time request at T+6
    cyc();
    sel_req = 1'b1; sel_addr = 5'd3;
    #1;
    check("t1_ack", 64'(sel_ack), 64'(1));
    check("t1_err", 64'(sel_err), 64'(0));
    for (int k = 1; k <= 14; k++) begin
      cyc();
      sel_req = (k == 6);
      #1;
      if (k <= G) begin
        check("drain_ena",  64'(proj_ena), 64'(0));
        check("drain_busy", 64'(busy),     64'(1));
        check("drain_iw",   64'(proj_iw),  64'(0));
      end else if (k <= G + H) begin
        check("rsth_ena",  64'(proj_ena), 64'(16'h0008));
        check("rsth_cur",  64'(cur_sel),  64'(3));
        check("rsth_iw",   64'(proj_iw),  64'(18'h3FFFD));
        check("rsth_done", 64'(sel_done), 64'(0));
      end
      if (k == 6) begin
        check("busy_ack", 64'(sel_ack), 64'(0));
        check("busy_err", 64'(sel_err), 64'(0));
      end
      if (k == G + H + 1) begin
        check("done_pulse", 64'(sel_done), 64'(1));
        check("done_busy",  64'(busy),     64'(0));
        check("act_ena",    64'(proj_ena), 64'(16'h0008));
      end
      if (k == G + H + 2) check("done_clr", 64'(sel_done), 64'(0));
    end

    // ACTIVE on 3: ext_ow scoreboard and iw pass-through
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (sb_q.size() > 0) begin
        check("ext_ow_sb", 64'(ext_ow), 64'(sb_q.pop_front()));
        if (i == 6) check("oe_mask", 64'(ext_ow[15:8]),
`ifdef MUX_SCHED_OE_MASK_EN
          64'(8'h0F));
`else
          64'(8'hFF));
`endif
      end
      rand_ow();
      if (i == 0) proj_ow[3*OW_W +: OW_W] = 24'hA55AC3;
      if (i == 5) proj_ow[3*OW_W +: OW_W] = 24'h0FFF00;
      ext_iw = 18'($urandom);
      sb_q.push_back(exp_ow(proj_ow[3*OW_W +: OW_W]));
      #1;
      check("act_iw", 64'(proj_iw), 64'(ext_iw));
    end
    cyc();
    if (sb_q.size() > 0) check("ext_ow_sb", 64'(ext_ow), 64'(sb_q.pop_front()));

    // Switch from ACTIVE 3 to project 5
    sel_req = 1'b1; sel_addr = 5'd5;
    #1;
    check("sw_ack", 64'(sel_ack), 64'(1));
    for (int k = 1; k <= G + H + 1; k++) begin
      cyc();
      sel_req = 1'b0;
      #1;
      if (k == 1) begin
        check("sw_ena0", 64'(proj_ena), 64'(0));
        check("sw_cur0", 64'(cur_sel),  64'(0));
        check("sw_ow0",  64'(ext_ow),   64'(0));
      end
      if (k == G + H + 1) begin
        check("sw_done", 64'(sel_done), 64'(1));
        check("sw_cur",  64'(cur_sel),  64'(5));
        check("sw_ena",  64'(proj_ena), 64'(16'h0020));
      end
    end

    // sel_off wins over a same-cycle sel_req
    cyc();
    sel_off = 1'b1; sel_req = 1'b1; sel_addr = 5'd2;
    #1;
    check("off_ack", 64'(sel_ack), 64'(0));
    check("off_err", 64'(sel_err), 64'(0));
    for (int k = 1; k <= G + 1; k++) begin
      cyc();
      sel_off = 1'b0; sel_req = 1'b0;
      #1;
      if (k == 1) begin
        check("off_ena",  64'(proj_ena), 64'(0));
        check("off_busy", 64'(busy),     64'(1));
        check("off_ow",   64'(ext_ow),   64'(0));
      end
      if (k == G) check("off_busy_end", 64'(busy), 64'(1));
      if (k == G + 1) begin
        check("idle_busy", 64'(busy),     64'(0));
        check("idle_cur",  64'(cur_sel),  64'(0));
        check("idle_ena",  64'(proj_ena), 64'(0));
      end
    end

    // Out-of-range address in IDLE
    cyc();
    sel_req = 1'b1; sel_addr = 5'd16;
    #1;
    check("oor_err", 64'(sel_err), 64'(1));
    check("oor_ack", 64'(sel_ack), 64'(0));
    cyc();
    sel_req = 1'b0;
    #1;
    check("oor_busy", 64'(busy),     64'(0));
    check("oor_ena",  64'(proj_ena), 64'(0));
    check("oor_cur",  64'(cur_sel),  64'(0));

    // Reset during the RESET hold aborts to IDLE
    ext_iw = '1;
    rand_ow();
    cyc();
    sel_req = 1'b1; sel_addr = 5'd7;
    #1;
    check("ab_ack", 64'(sel_ack), 64'(1));
    for (int k = 1; k <= G + 3; k++) begin
      cyc();
      sel_req = 1'b0;
    end
    #1;
    check("ab_pre_ena", 64'(proj_ena), 64'(16'h0080));
    rst = 1'b1;
    cyc();
    #1;
    check("ab_ena",  64'(proj_ena), 64'(0));
    check("ab_ow",   64'(ext_ow),   64'(0));
    check("ab_iw",   64'(proj_iw),  64'(0));
    check("ab_busy", 64'(busy),     64'(0));
    check("ab_cur",  64'(cur_sel),  64'(0));
    rst = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
